// File: rtl/arbiter_memory_packet_n_to_1_pkg.sv
// Shared MemoryPacket / FIFO-state types and the arbiter FSM encoding for
// the N-to-1 packet arbiter and its FIFOs.
package arbiter_memory_packet_n_to_1_pkg;

  typedef enum logic {ARB_RESET, ARB_ACTIVE} type_arbiter_state;

  typedef struct packed {
    logic [7:0] hops;
    logic [7:0] dest;
  } MemoryPacketRoute;

  typedef struct packed {
    MemoryPacketRoute route;
    logic [15:0]      seq_id;
  } MemoryPacketMeta;

  typedef struct packed {
    MemoryPacketMeta meta;
    logic [31:0]     data;
  } MemoryPacketPayload;

  typedef struct packed {
    logic               valid;
    MemoryPacketPayload payload;
  } MemoryPacket;

  typedef struct packed {
    logic rd_en;
  } FIFOStateSignalsInput;

  typedef struct packed {
    logic empty;
    logic prog_full;
  } FIFOStateSignalsOutput;

  typedef struct packed {
    logic empty;
    logic full;
    logic prog_full;
  } FIFOStateSignalsOutInternal;

  function automatic FIFOStateSignalsOutput map_internal_fifo_signals_to_output(
    input FIFOStateSignalsOutInternal s);
    FIFOStateSignalsOutput o;
    o.empty     = s.empty;
    o.prog_full = s.prog_full;
    return o;
  endfunction

endpackage

// File: rtl/arbiter_memory_packet_n_to_1_fifo.sv
// Synchronous MemoryPacket payload FIFO with show-ahead head and registered
// empty/full/prog_full flags derived from the next-cycle fill count.
module fifo_memory_packet_sync
  import arbiter_memory_packet_n_to_1_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int PROG_THRESH = 12
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic                       rd_en,
  input  MemoryPacketPayload         din,
  output MemoryPacketPayload         dout,
  output FIFOStateSignalsOutInternal state
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  MemoryPacketPayload mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_next;
  logic          do_wr, do_rd;

  // Full blocks writes even when a read happens in the same cycle.
  assign do_wr = wr_en && !state.full;
  assign do_rd = rd_en && !state.empty;
  assign dout  = mem[rd_ptr];

  function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    count_next = count;
    if (do_wr && !do_rd)      count_next = count + 1'b1;
    else if (do_rd && !do_wr) count_next = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      state  <= '{empty: 1'b1, full: 1'b0, prog_full: 1'b0};
    end else begin
      if (do_wr) wr_ptr <= wrap_inc(wr_ptr);
      if (do_rd) rd_ptr <= wrap_inc(rd_ptr);
      count           <= count_next;
      state.empty     <= (count_next == '0);
      state.full      <= (count_next == CW'(DEPTH));
      state.prog_full <= (count_next >= CW'(PROG_THRESH));
    end
  end

  always_ff @(posedge clk)
    if (do_wr) mem[wr_ptr] <= din;

endmodule

// File: rtl/arbiter_memory_packet_n_to_1.sv
// N-to-1 round-robin MemoryPacket arbiter: per-channel skid buffers into a
// shared output FIFO. Define ARBITER_MEMORY_PACKET_HOPS_EN to bump route.hops on grant.
module arbiter_memory_packet_n_to_1
  import arbiter_memory_packet_n_to_1_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int FIFO_DEPTH   = 16,
  parameter int PROG_THRESH  = 12,
  parameter int IN_BUF_DEPTH = 2
) (
  input  logic                          ap_clk,
  input  logic                          areset,
  input  MemoryPacket [NUM_CHANNELS-1:0] request_in,
  output logic [NUM_CHANNELS-1:0]       request_in_ready,
  input  FIFOStateSignalsInput          fifo_request_signals_in,
  output FIFOStateSignalsOutput         fifo_request_signals_out,
  output MemoryPacket                   request_out,
  output logic [NUM_CHANNELS-1:0]       grant_out
);
  localparam int GW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

  type_arbiter_state          state, state_next;
  logic [GW-1:0]              ptr, gidx;
  logic [NUM_CHANNELS-1:0]    grant;
  logic [NUM_CHANNELS-1:0]    in_pf_unused;
  MemoryPacketPayload         in_head  [NUM_CHANNELS];
  FIFOStateSignalsOutInternal in_state [NUM_CHANNELS];
  MemoryPacketPayload         win, out_head;
  FIFOStateSignalsOutInternal out_state;

  always_ff @(posedge ap_clk)
    if (areset) state <= ARB_RESET;
    else        state <= state_next;

  always_comb begin
    state_next = state;
    case (state)
      ARB_RESET:  state_next = ARB_ACTIVE;
      ARB_ACTIVE: state_next = ARB_ACTIVE;
      default:    state_next = ARB_RESET;
    endcase
  end

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
    assign request_in_ready[i] = (state == ARB_ACTIVE) && !in_state[i].full;
    assign in_pf_unused[i]     = in_state[i].prog_full;

    fifo_memory_packet_sync #(.DEPTH(IN_BUF_DEPTH), .PROG_THRESH(IN_BUF_DEPTH)) u_buf (
      .clk   (ap_clk),
      .reset (areset),
      .wr_en (request_in[i].valid && request_in_ready[i]),
      .rd_en (grant[i]),
      .din   (request_in[i].payload),
      .dout  (in_head[i]),
      .state (in_state[i])
    );

    // A packet offered without ready is lost; producers must honour ready.
    ap_no_drop: assert property (@(posedge ap_clk) disable iff (areset)
      request_in[i].valid |-> request_in_ready[i]);
  end

  // Round-robin search starting just after the last granted channel.
  always_comb begin
    logic [GW-1:0] idx;
    grant = '0;
    gidx  = ptr;
    idx   = '0;
    if (state == ARB_ACTIVE && !out_state.full)
      for (int k = 1; k <= NUM_CHANNELS; k++) begin
        idx = GW'((int'(ptr) + k) % NUM_CHANNELS);
        if (grant == '0 && !in_state[idx].empty) begin
          grant[idx] = 1'b1;
          gidx       = idx;
        end
      end
  end

  always_comb begin
    win = in_head[gidx];
`ifdef ARBITER_MEMORY_PACKET_HOPS_EN
    if (win.meta.route.hops != '1)
      win.meta.route.hops = win.meta.route.hops + 1'b1;
`endif
  end

  always_ff @(posedge ap_clk)
    if (areset)          ptr <= GW'(NUM_CHANNELS - 1);
    else if (grant != '0) ptr <= gidx;

  fifo_memory_packet_sync #(.DEPTH(FIFO_DEPTH), .PROG_THRESH(PROG_THRESH)) u_out (
    .clk   (ap_clk),
    .reset (areset),
    .wr_en (|grant),
    .rd_en (fifo_request_signals_in.rd_en),
    .din   (win),
    .dout  (out_head),
    .state (out_state)
  );

  assign fifo_request_signals_out = map_internal_fifo_signals_to_output(out_state);
  assign grant_out                = grant;

  // Payload holds after a pop so downstream can sample it late.
  always_ff @(posedge ap_clk) begin
    if (areset) begin
      request_out <= '0;
    end else if (fifo_request_signals_in.rd_en && !out_state.empty) begin
      request_out.valid   <= 1'b1;
      request_out.payload <= out_head;
    end else begin
      request_out.valid <= 1'b0;
    end
  end

  logic unused_ok;
  assign unused_ok = ^in_pf_unused;

endmodule
